lvds_align_ctrl: RTL and testbench

//  Word-alignment controller behind the 8-lane DDR LVDS capture stage (16-bit word per clk).
//  - Raw capture words arrive at an arbitrary bit offset.
//  - On start, the block walks bit offsets 0..DATA_W-1 against a repeating training pattern.
//  - It locks on the first offset that yields MATCH_CNT consecutive matches, then forwards aligned words.
//  - Sits between the LVDS capture block and the sample consumers; sequences the capture path bring-up.

---
 rtl/lvds_pkg.sv | 20 ++
 rtl/lvds_word_aligner.sv | 29 ++
 rtl/lvds_align_ctrl.sv | 123 ++++++++++++
 tb/tb_lvds_align_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS capture word-alignment path.
package lvds_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        LOCKED,
        FAIL
    } state_t;

    localparam int LVDS_WORD_W = 16;

    localparam logic [LVDS_WORD_W-1:0] TRAIN_PATTERN_DEF = 16'h00FF;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lvds_word_aligner.sv
// Barrel-select of one DATA_W word out of the current and previous capture words.
// Combinational select; prev advances on every valid word regardless of controller state.
module lvds_word_aligner #(
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic [$clog2(DATA_W)-1:0] offset,
    output logic [DATA_W-1:0]         aligned
);

    logic [DATA_W-1:0]   prev;
    logic [2*DATA_W-1:0] win_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else if (in_valid) begin
            prev <= in_data;
        end
    end

    // offset 0 passes prev through untouched; higher offsets pull bits from in_data
    assign win_shift = {in_data, prev} >> offset;
    assign aligned   = win_shift[DATA_W-1:0];

endmodule

// File: rtl/lvds_align_ctrl.sv
// Walks bit offsets against a training word, locks on the first stable one, then forwards aligned words.
// One-cycle registered output latency once locked; all counting stalls while in_valid is low.
module lvds_align_ctrl
    import lvds_pkg::*;
#(
    parameter int                DATA_W        = LVDS_WORD_W,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter int                SETTLE_CYC    = 4,
    parameter int                MATCH_CNT     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic [$clog2(DATA_W)-1:0] offset,
    output logic                      busy,
    output logic                      locked,
    output logic                      fail
);

    localparam int OFF_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(max2(SETTLE_CYC, MATCH_CNT) + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MATCH_LAST  = CNT_W'(MATCH_CNT - 1);
    localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  settle_nxt;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  match_nxt;
    logic [OFF_W-1:0]  offset_nxt;
    logic [DATA_W-1:0] aligned;
    logic              hit;
    logic              emit;

    lvds_word_aligner #(
        .DATA_W (DATA_W)
    ) u_aligner (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .offset   (offset),
        .aligned  (aligned)
    );

    assign hit  = (aligned == TRAIN_PATTERN);
    // a restart request in the same cycle suppresses the word so out_valid drops at once
    assign emit = (state == LOCKED) && in_valid && !start;

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        match_nxt  = match_cnt;
        offset_nxt = offset;
        case (state)
            IDLE, LOCKED, FAIL: begin
                if (start) begin
                    state_nxt  = SETTLE;
                    offset_nxt = '0;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                if (in_valid) begin
                    settle_nxt = settle_cnt + CNT_W'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt = CHECK;
                        match_nxt = '0;
                    end
                end
            end
            CHECK: begin
                if (in_valid) begin
                    if (hit) begin
                        match_nxt = match_cnt + CNT_W'(1);
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt = LOCKED;
                        end
                    end else if (offset == OFF_LAST) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt  = SETTLE;
                        offset_nxt = offset + OFF_W'(1);
                        settle_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            offset     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            match_cnt  <= match_nxt;
            offset     <= offset_nxt;
            out_valid  <= emit;
            if (emit) begin
                out_data <= aligned;
            end
        end
    end

    assign busy   = (state == SETTLE) || (state == CHECK);
    assign locked = (state == LOCKED);
    assign fail   = (state == FAIL);

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Randomized scoreboard bench for lvds_align_ctrl against a word-level reference model.
module tb_lvds_align_ctrl;

    localparam int          W = 16;
    localparam int          S = 4;
    localparam int          M = 8;
    localparam logic [15:0] P = 16'h00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic [3:0]  offset;
    logic        busy;
    logic        locked;
    logic        fail;

    lvds_align_ctrl #(
        .DATA_W        (W),
        .TRAIN_PATTERN (P),
        .SETTLE_CYC    (S),
        .MATCH_CNT     (M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .offset    (offset),
        .busy      (busy),
        .locked    (locked),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] stream[$];
    logic [15:0] last_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
        logic [31:0] d;
        d = {v, v} << k;
        return d[31:16];
    endfunction

    // The word seen at bit offset k: the serial stream is prev followed by cur, skipping k bits.
    function automatic logic [15:0] align_of(input logic [15:0] cur, input logic [15:0] prv, input int k);
        logic [31:0] win;
        win = {cur, prv} >> k;
        return win[15:0];
    endfunction

    // Reference: consume S words per offset, then count matches until M in a row or a miss.
    task automatic model(input logic [15:0] p0, output bit lk, output int off, output int cnt);
        int pos;
        int m;
        logic [15:0] prv;
        pos = 0;
        for (int k = 0; k < W; k++) begin
            pos += S;
            m = 0;
            while (1) begin
                prv = (pos == 0) ? p0 : stream[pos-1];
                if (align_of(stream[pos], prv, k) == P) begin
                    pos++;
                    m++;
                    if (m == M) begin
                        lk = 1'b1; off = k; cnt = pos;
                        return;
                    end
                end else begin
                    pos++;
                    break;
                end
            end
        end
        lk = 1'b0; off = W - 1; cnt = pos;
    endtask

    task automatic feed(input logic [15:0] w, input int gap_mode, input bit with_start);
        int g;
        g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (g) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        start    = with_start;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        start     = 1'b0;
        last_word = w;
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("locked_after_start", locked, 0);
        check("fail_after_start", fail, 0);
        check("out_valid_after_start", out_valid, 0);
    endtask

    task automatic run_case(input string name, input int gap_mode, input int ign_at, input int extra);
        bit lk;
        int off;
        int cnt;
        logic [15:0] w;
        model(last_word, lk, off, cnt);
        pulse_start();
        for (int n = 1; n <= cnt; n++) begin
            feed(stream[n-1], gap_mode, n == ign_at);
            if (n == cnt - 1) check({name, "_pre_done"}, {locked, fail}, 2'b00);
        end
        check({name, "_locked"}, locked, lk);
        check({name, "_fail"}, fail, !lk);
        check({name, "_offset"}, offset, off);
        check({name, "_busy"}, busy, 0);
        for (int j = 0; j < extra; j++) begin
            w = 16'($urandom);
            if (lk) exp_q.push_back(align_of(w, last_word, off));
            feed(w, gap_mode, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic fill_const(input logic [15:0] w);
        stream.delete();
        for (int i = 0; i < 220; i++) stream.push_back(w);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: got out_valid=1 data=%0h, expected no output", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] base;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        last_word = '0;
        #12;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_offset", offset, 0);
        check("rst_flags", {busy, locked, fail}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // aligned stream; a start pulse mid-CHECK must be ignored
        fill_const(P);
        run_case("c1", 0, 7, 10);
        // restart from LOCKED re-locks at the same offset
        run_case("c5", 0, 0, 6);

        fill_const(rotl(P, 5));
        run_case("c2", 0, 0, 8);
        run_case("c4", 1, 0, 8);

        fill_const(16'h0000);
        run_case("c3", 0, 0, 5);

        // reset during CHECK at offset 3: 3 rejected offsets plus 4 settle words
        fill_const(rotl(P, 5));
        pulse_start();
        for (int n = 0; n < 3 * (S + 1) + S; n++) feed(stream[n], 0, 1'b0);
        check("c6_pre_offset", offset, 3);
        check("c6_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("c6_rst_flags", {busy, locked, fail, out_valid}, 4'b0000);
        check("c6_rst_offset", offset, 0);
        #10 rst = 1'b0;
        last_word = '0;
        @(posedge clk); #1;
        run_case("c6", 0, 0, 6);

        // random offsets with sporadic corrupted words and random in_valid gaps
        for (int t = 0; t < 8; t++) begin
            base = rotl(P, $urandom_range(0, 15));
            stream.delete();
            for (int i = 0; i < 220; i++) begin
                if (i < 40 && $urandom_range(0, 5) == 0) stream.push_back(16'($urandom));
                else stream.push_back(base);
            end
            run_case("rnd", $urandom_range(0, 2), 0, 8);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
